ram_8_burst_ctrl: RTL and testbench
===================================

Name: ram_8_burst_ctrl

Overview:
- Sequencing front end that sits directly upstream of ram_8 and owns its in/address/load pins.
- Accepts one burst command per handshake (READ, WRITE or CLEAR) of 1..8 words starting at any address; address wraps modulo 8.
- Streams write data in and read data out over valid/ready channels.
- ram_8 output (combinational from its registers) is fed back as ram_out.

Parameters:
- WIDTH, 16, data word width; must match ram_8 (fixed 16 in this design).
- DEPTH_BITS, 3, address width; burst length and wrap are modulo 2**DEPTH_BITS.

Ports:
- clock  input  1  single rising-edge clock shared with ram_8
- reset_n  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller idle, command accepted when valid&&ready
- cmd_op  input  2  0=READ, 1=WRITE, 2=CLEAR, 3=reserved (accepted, treated as no-op)
- cmd_addr  input  3  start address
- cmd_len  input  3  burst length minus one (0 → 1 word, 7 → 8 words)
- wr_valid  input  1  write word present
- wr_ready  output  1  write word consumed this cycle when valid&&ready
- wr_data  input  16  write word
- rd_valid  output  1  read word present
- rd_ready  input  1  read word consumed when valid&&ready
- rd_data  output  16  read word
- busy  output  1  high in any non-IDLE state
- ram_in  output  16  to ram_8 in
- ram_address  output  3  to ram_8 address (registered)
- ram_load  output  1  to ram_8 load
- ram_out  input  16  from ram_8 out

Behaviour:
- Reset: clock and reset are as decided above: one clock; reset is synchronous and active-low. Any edge with reset_n=0 forces state=IDLE, addr=0, remaining=0. Does not clear RAM contents.
- Outputs while reset_n=0: cmd_ready=0, wr_ready=0, rd_valid=0, ram_load=0, busy=0, ram_in=0, ram_address=0.
- Reset asserted mid-burst aborts it; no partial-cycle write occurs on the reset edge.
- IDLE: cmd_ready=1. On cmd_valid, the next edge latches addr=cmd_addr and remaining=cmd_len, then enters WRITE (op 1), READ (op 0) or CLEAR (op 2). Op 3 stays IDLE. Zero-cycle command acceptance latency.
- WRITE:
  - wr_ready=1, ram_in=wr_data, ram_load=wr_valid.
  - Each accepted word is written at addr on that edge, and the same edge advances addr=(addr+1) mod 8.
  - When a word is accepted with remaining=0, return to IDLE; otherwise remaining decrements.
  - wr_valid=0 stalls with no write and no advance.
- READ:
  - rd_valid=1, rd_data=ram_out (ram_address=addr), ram_load=0.
  - On rd_ready the edge advances addr and decrements remaining; the last word returns to IDLE.
  - rd_ready=0 holds addr and rd_data stable.
- CLEAR: ram_in=0, ram_load=1 every cycle, one word per cycle, no handshake. Length is cmd_len+1 cycles, then IDLE.
- ram_address equals addr in all states; it is 0 in IDLE after reset and holds the last value otherwise.
- wr_ready is 0 outside WRITE; rd_valid is 0 outside READ. Words offered outside a burst are ignored.
- Wrap: a burst with start address 6 and cmd_len 3 touches addresses 6, 7, 0, 1.
- Throughput: one word per cycle sustained. A new command is accepted at the earliest in the cycle after the final word.

Decomposition:
- Package n2t_mem_pkg:
  - op enum (OP_READ, OP_WRITE, OP_CLEAR, OP_RSVD)
  - state enum (S_IDLE, S_WRITE, S_READ, S_CLEAR)
  - ADDR_W=3, WORD_W=16
- One sub-module, wrap_counter_3: 3-bit loadable, enable-gated counter with synchronous active-low reset. Two instances: address (incrementing, wraps) and remaining (decrementing, exposes zero flag).
- FSM and datapath muxing are in the top module.

Test Plan:
- Reset, then WRITE addr=0 len=7 with data 0x1000..0x1007 streamed back-to-back → 8 ram_load pulses on addresses 0..7, busy low on the 9th cycle. A following READ addr=0 len=7 with rd_ready=1 returns 0x1000..0x1007 in order.
- WRITE addr=6 len=3 with data 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD → addresses 6, 7, 0, 1 written. READ addr=6 len=3 returns the same four words (wrap check).
- READ len=2 with rd_ready toggling 1,0,0,1,1 → rd_data holds steady during the stall, and exactly 3 words are delivered with no duplicates.
- CLEAR addr=2 len=1 → ram_load high for exactly 2 cycles at addresses 2 and 3 with ram_in=0. READ addr=1 len=3 returns old@1, 0x0000, 0x0000, old@4.
- WRITE len=7, with reset_n driven low after the 3rd accepted word → no further writes, cmd_ready=0 while in reset, IDLE with address 0 after release. Addresses 0..2 hold the new data; 3..7 are unchanged.
- cmd_op=3 and stray wr_valid/rd_ready in IDLE → no ram_load, busy stays 0, cmd_ready stays 1.

Source files
------------

// File: rtl/n2t_mem_pkg.sv
// Shared types and widths for the ram_8 burst front end.
// Op and state encodings live here so the controller and its checkers agree.
package n2t_mem_pkg;

  localparam int ADDR_W = 3;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  typedef struct packed {
    state_e            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic              addr_at_base;
  } dbg_t;

  // Burst state entered for a command; the reserved op stays idle.
  function automatic state_e op_to_state(input op_e op);
    state_e s;
    unique case (op)
      OP_READ:  s = S_READ;
      OP_WRITE: s = S_WRITE;
      OP_CLEAR: s = S_CLEAR;
      default:  s = S_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wrap_counter_3.sv
// 3-bit loadable counter, enable-gated, wrapping modulo 8 in either direction.
// Load wins over enable; zero flags a count of 0.
module wrap_counter_3 #(
  parameter bit DOWN = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic [2:0] count,
  output logic       zero
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = DOWN ? (count_q - 3'd1) : (count_q + 3'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 3'd0);

endmodule

// File: rtl/ram_8_burst_ctrl.sv
// Burst sequencer driving ram_8's in/address/load pins from READ/WRITE/CLEAR commands.
// Handshakes: a word moves on an edge only when its valid and ready are both high.
module ram_8_burst_ctrl
  import n2t_mem_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int DEPTH_BITS = ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DEPTH_BITS-1:0] cmd_addr,
  input  logic [DEPTH_BITS-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy,
  output logic [WIDTH-1:0]      ram_in,
  output logic [DEPTH_BITS-1:0] ram_address,
  output logic                  ram_load,
  input  logic [WIDTH-1:0]      ram_out,
  output dbg_t                  dbg
);

  state_e     state_q;
  state_e     state_d;
  logic       cmd_fire;
  logic       step;
  logic [2:0] addr;
  logic [2:0] remaining;
  logic       addr_zero;
  logic       rem_zero;

  assign cmd_fire = (state_q == S_IDLE) && cmd_valid;

  // One word moves per step; CLEAR steps every cycle with no handshake.
  always_comb begin
    step = 1'b0;
    unique case (state_q)
      S_WRITE: step = wr_valid;
      S_READ:  step = rd_ready;
      S_CLEAR: step = 1'b1;
      default: step = 1'b0;
    endcase
  end

  wrap_counter_3 #(.DOWN(1'b0)) u_addr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cmd_fire),
    .load_val (cmd_addr),
    .en       (step),
    .count    (addr),
    .zero     (addr_zero)
  );

  wrap_counter_3 #(.DOWN(1'b1)) u_remaining (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cmd_fire),
    .load_val (cmd_len),
    .en       (step),
    .count    (remaining),
    .zero     (rem_zero)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (cmd_valid) state_d = op_to_state(op_e'(cmd_op));
    end else if (step && rem_zero) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Everything facing ram_8 or the host is forced quiet while reset is held,
  // so an abort on the reset edge never commits a partial write.
  always_comb begin
    cmd_ready   = reset_n && (state_q == S_IDLE);
    wr_ready    = reset_n && (state_q == S_WRITE);
    rd_valid    = reset_n && (state_q == S_READ);
    busy        = reset_n && (state_q != S_IDLE);
    rd_data     = ram_out;
    ram_in      = (reset_n && (state_q == S_WRITE)) ? wr_data : '0;
    ram_load    = reset_n && (((state_q == S_WRITE) && wr_valid) || (state_q == S_CLEAR));
    ram_address = reset_n ? addr : '0;
  end

  always_comb begin
    dbg.state        = state_q;
    dbg.addr         = addr;
    dbg.remaining    = remaining;
    dbg.addr_at_base = addr_zero;
  end

endmodule

// File: tb/tb_ram_8_burst_ctrl.sv
// Bench for ram_8_burst_ctrl with a behavioural ram_8 on its memory pins.
// Expected RAM writes and read words are queued as stimulus is driven and popped by a monitor.
module tb_ram_8_burst_ctrl;
  import n2t_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        busy;
  logic [15:0] ram_in;
  logic [2:0]  ram_address;
  logic        ram_load;
  logic [15:0] ram_out;
  dbg_t        dbg;

  logic [15:0] ram_mem   [8];
  logic [15:0] mem_model [8];
  logic [15:0] wbuf      [8];
  logic [18:0] wr_exp_q  [$];
  logic [15:0] rd_exp_q  [$];
  int          n_vec = 0;
  int          n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  ram_8_burst_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .busy        (busy),
    .ram_in      (ram_in),
    .ram_address (ram_address),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .dbg         (dbg)
  );

  // Behavioural ram_8: registered write, combinational read.
  always @(posedge clock) if (ram_load) ram_mem[ram_address] <= ram_in;
  assign ram_out = ram_mem[ram_address];

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_cycle();
    logic [18:0] wexp;
    @(negedge clock);
    if (ram_load) begin
      n_vec++;
      if (wr_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ram_write_unexpected: got addr=%0d data=%h, required no write", ram_address, ram_in);
      end else begin
        wexp = wr_exp_q.pop_front();
        if ({ram_address, ram_in} !== wexp) begin
          n_err++;
          $display("FAIL ram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   ram_address, ram_in, wexp[18:16], wexp[15:0]);
        end
      end
    end
    if (rd_valid) begin
      n_vec++;
      if (rd_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_valid_unexpected: got rd_data=%h, required rd_valid=0", rd_data);
      end else begin
        if (rd_data !== rd_exp_q[0]) begin
          n_err++;
          $display("FAIL rd_data: got %h, required %h", rd_data, rd_exp_q[0]);
        end
        if (rd_ready) void'(rd_exp_q.pop_front());
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] l);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_ready_before_cmd: got %b, required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [2:0] l, input bit stalls);
    logic [2:0] wa;
    issue_cmd(2'd1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (stalls && ($urandom_range(0, 1) == 1)) begin
        wr_valid = 1'b0;
        wr_data  = 16'($urandom);
        tick();
      end
      wa       = a + 3'(i);
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      wr_exp_q.push_back({wa, wbuf[i]});
      mem_model[wa] = wbuf[i];
      tick();
    end
    wr_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL write_end: got busy=%b cmd_ready=%b, required busy=0 cmd_ready=1", busy, cmd_ready);
    end
  endtask

  task automatic do_read(input logic [2:0] a, input logic [2:0] l, input logic [4:0] pat, input bit use_pat);
    int cyc;
    for (int i = 0; i <= int'(l); i++) rd_exp_q.push_back(mem_model[a + 3'(i)]);
    issue_cmd(2'd0, a, l);
    cyc = 0;
    while (rd_exp_q.size() > 0 && cyc < 40) begin
      rd_ready = (use_pat && cyc < 5) ? pat[cyc] : 1'b1;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    n_vec++;
    if (rd_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL read_timeout: got %0d words outstanding, required 0", rd_exp_q.size());
      rd_exp_q.delete();
    end
    n_vec++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_end: got busy=%b rd_valid=%b, required 0 0", busy, rd_valid);
    end
  endtask

  task automatic do_clear(input logic [2:0] a, input logic [2:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      wr_exp_q.push_back({a + 3'(i), 16'h0000});
      mem_model[a + 3'(i)] = 16'h0000;
    end
    issue_cmd(2'd2, a, l);
    repeat (int'(l) + 1) tick();
    n_vec++;
    if (busy !== 1'b0 || wr_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clear_end: got busy=%b pending=%0d, required busy=0 pending=0", busy, wr_exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (cmd_ready !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || ram_load !== 1'b0 ||
        busy !== 1'b0 || ram_in !== 16'h0 || ram_address !== 3'd0) begin
      n_err++;
      $display("FAIL %s: got cmd_ready=%b wr_ready=%b rd_valid=%b ram_load=%b busy=%b ram_in=%h ram_address=%0d, required all 0",
               tag, cmd_ready, wr_ready, rd_valid, ram_load, busy, ram_in, ram_address);
    end
  endtask

  task automatic check_idle_after_reset(input string tag);
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || ram_address !== 3'd0 || dbg.state !== S_IDLE) begin
      n_err++;
      $display("FAIL %s: got cmd_ready=%b busy=%b ram_address=%0d state=%0d, required 1 0 0 IDLE",
               tag, cmd_ready, busy, ram_address, dbg.state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset_outputs");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_idle_after_reset("reset_release");
    tick();
  endtask

  task automatic test_linear();
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h1000 + 16'(i);
    do_write(3'd0, 3'd7, 1'b0);
    do_read(3'd0, 3'd7, 5'b11111, 1'b0);
  endtask

  task automatic test_wrap();
    wbuf[0] = 16'hAAAA;
    wbuf[1] = 16'hBBBB;
    wbuf[2] = 16'hCCCC;
    wbuf[3] = 16'hDDDD;
    do_write(3'd6, 3'd3, 1'b1);
    do_read(3'd6, 3'd3, 5'b11111, 1'b0);
  endtask

  task automatic test_read_stall();
    do_read(3'd5, 3'd2, 5'b11001, 1'b1);
  endtask

  task automatic test_clear();
    do_clear(3'd2, 3'd1);
    do_read(3'd1, 3'd3, 5'b11111, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h2000 + 16'(i);
    issue_cmd(2'd1, 3'd0, 3'd7);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      wr_exp_q.push_back({3'(i), wbuf[i]});
      mem_model[i] = wbuf[i];
      tick();
    end
    wr_data = wbuf[3];
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset_mid_burst");
    tick();
    tick();
    wr_valid = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);
    check_idle_after_reset("reset_mid_release");
    tick();
    do_read(3'd0, 3'd7, 5'b11111, 1'b0);
  endtask

  task automatic test_rsvd_idle();
    issue_cmd(2'd3, 3'd5, 3'd2);
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 16'hBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_vec++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || ram_load !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rsvd_idle: got busy=%b cmd_ready=%b ram_load=%b wr_ready=%b rd_valid=%b, required 0 1 0 0 0",
                 busy, cmd_ready, ram_load, wr_ready, rd_valid);
      end
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] a;
    logic [2:0] l;
    for (int r = 0; r < 4; r++) begin
      a = 3'($urandom_range(0, 7));
      l = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
      do_write(a, l, 1'b1);
      do_read(a, l, 5'($urandom_range(1, 31)), 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 3'd0;
    cmd_len   = 3'd0;
    wr_valid  = 1'b0;
    wr_data   = 16'h0;
    rd_ready  = 1'b0;
    for (int i = 0; i < 8; i++) mem_model[i] = 16'h0;
    fork
      forever monitor_cycle();
    join_none

    test_reset();
    test_linear();
    test_wrap();
    test_read_stall();
    test_clear();
    test_reset_mid_burst();
    test_rsvd_idle();
    test_back_to_back();

    tick();
    n_vec++;
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d writes %0d reads pending, required 0 0",
               wr_exp_q.size(), rd_exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
